// File: rtl/decode_nia_regfile.sv
// Decode-stage core: MIPS-I instruction decoder, next-instruction-address
// calculator and a 32x32 register file with three read ports and write bypass.
module decode_nia_regfile #(
  parameter string TAG = ""
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC,
  input  logic [31:0] Instr_PC_Plus4,
  input  logic [31:0] RegisterValue,
  input  logic        FWD_REQ_FREEZE,
  input  logic        comment1,
  input  logic [4:0]  RegA,
  input  logic [4:0]  RegB,
  input  logic [4:0]  RegC,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [31:0] NextInstructionAddress
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_LL      = 6'h30;
  localparam logic [5:0] OP_SC      = 6'h38;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [5:0] ALU_ADDU   = 6'b100001;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;

  assign op    = Instr[31:26];
  assign funct = Instr[5:0];
  assign rt    = Instr[20:16];

  // Debug-only inputs carry no function in hardware.
  logic unused_ok;
  assign unused_ok = ^{comment1, Instr_PC, (TAG == "")};

  // Instruction decode
  always_comb begin
    Link         = 1'b0;
    RegDest      = 1'b0;
    Jump         = 1'b0;
    Branch       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    JumpRegister = 1'b0;
    SignOrZero   = 1'b0;
    Syscall      = 1'b0;
    ALUControl   = 6'b000000;

    case (op)
      OP_SPECIAL: begin
        // The all-zero word is treated as unsupported rather than SLL $0.
        if (Instr != 32'h0000_0000) begin
          case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: begin
              RegDest    = 1'b1;
              RegWrite   = 1'b1;
              ALUControl = funct;
            end
            FN_JR: begin
              Jump         = 1'b1;
              JumpRegister = 1'b1;
              Branch       = 1'b1;
              ALUControl   = funct;
            end
            FN_JALR: begin
              Link         = 1'b1;
              RegDest      = 1'b1;
              Jump         = 1'b1;
              JumpRegister = 1'b1;
              Branch       = 1'b1;
              RegWrite     = 1'b1;
              ALUControl   = funct;
            end
            FN_SYSCALL: begin
              Syscall    = 1'b1;
              ALUControl = funct;
            end
            default: ;
          endcase
        end
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            Branch     = 1'b1;
            ALUControl = ALU_ADDU;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            Branch     = 1'b1;
            Link       = 1'b1;
            RegWrite   = 1'b1;
            ALUControl = ALU_ADDU;
          end
          default: ;
        endcase
      end
      OP_J: begin
        Jump       = 1'b1;
        Branch     = 1'b1;
        ALUControl = ALU_ADDU;
      end
      OP_JAL: begin
        Jump       = 1'b1;
        Branch     = 1'b1;
        Link       = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = ALU_ADDU;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        Branch     = 1'b1;
        ALUControl = ALU_ADDU;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        case (op)
          OP_ADDI:  ALUControl = 6'b100000;
          OP_ADDIU: ALUControl = 6'b100001;
          OP_SLTI:  ALUControl = 6'b101010;
          default:  ALUControl = 6'b101011;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
        case (op)
          OP_ANDI: ALUControl = 6'b100100;
          OP_ORI:  ALUControl = 6'b100101;
          OP_XORI: ALUControl = 6'b100110;
          default: ALUControl = 6'b001111;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        MemRead    = 1'b1;
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = ALU_ADDU;
      end
      OP_SB, OP_SH, OP_SW: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = ALU_ADDU;
      end
      // LL/SC are routed to the syscall path for emulation by the ID stage.
      OP_LL: begin
        Syscall    = 1'b1;
        MemRead    = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = 6'b101000;
      end
      OP_SC: begin
        Syscall    = 1'b1;
        MemWrite   = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = 6'b110110;
      end
      default: ;
    endcase
  end

  // Next instruction address; a forwarding freeze holds the sequential path.
  logic [31:0] branch_offset;
  assign branch_offset = {{14{Instr[15]}}, Instr[15:0], 2'b00};

  always_comb begin
    NextInstructionAddress = Instr_PC_Plus4;
    if (FWD_REQ_FREEZE) begin
      NextInstructionAddress = Instr_PC_Plus4;
    end else if (Jump && JumpRegister) begin
      NextInstructionAddress = RegisterValue;
    end else if (Jump) begin
      NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    end else if (Branch) begin
      NextInstructionAddress = DATA_W'(Instr_PC_Plus4 + branch_offset);
    end
  end

  // Register file storage
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = Write && RESET && (WriteReg != 5'd0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WriteReg] <= WriteData;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end else if (wr_en && (WriteReg == addr)) begin
      return WriteData;
    end else begin
      return regs[addr];
    end
  endfunction

  assign DataA = read_port(RegA);
  assign DataB = read_port(RegB);
  assign DataC = read_port(RegC);

endmodule

// File: tb/tb_decode_nia_regfile.sv
// Directed self-checking bench for decode_nia_regfile: register file
// write/bypass/reset behaviour and decoder/NIA vectors with hand-derived results.
module tb_decode_nia_regfile;

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic [31:0] Instr_PC_Plus4;
  logic [31:0] RegisterValue;
  logic        FWD_REQ_FREEZE;
  logic        comment1;
  logic [4:0]  RegA, RegB, RegC;
  logic [31:0] DataA, DataB, DataC;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Write;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc;
  logic        RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;
  logic [31:0] NextInstructionAddress;

  int n_cmp = 0;
  int n_err = 0;

  decode_nia_regfile #(.TAG("tb")) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Instr(Instr),
    .Instr_PC(Instr_PC),
    .Instr_PC_Plus4(Instr_PC_Plus4),
    .RegisterValue(RegisterValue),
    .FWD_REQ_FREEZE(FWD_REQ_FREEZE),
    .comment1(comment1),
    .RegA(RegA),
    .RegB(RegB),
    .RegC(RegC),
    .DataA(DataA),
    .DataB(DataB),
    .DataC(DataC),
    .WriteReg(WriteReg),
    .WriteData(WriteData),
    .Write(Write),
    .Link(Link),
    .RegDest(RegDest),
    .Jump(Jump),
    .Branch(Branch),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .ALUSrc(ALUSrc),
    .RegWrite(RegWrite),
    .JumpRegister(JumpRegister),
    .SignOrZero(SignOrZero),
    .Syscall(Syscall),
    .ALUControl(ALUControl),
    .NextInstructionAddress(NextInstructionAddress)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Flag order: Link RegDest Jump Branch MemRead MemWrite ALUSrc RegWrite JumpRegister SignOrZero Syscall
  task automatic dec_vec(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [31:0] rv, input logic frz, input logic [10:0] exp_flags,
                         input logic [5:0] exp_alu, input logic [31:0] exp_nia);
    Instr          = instr;
    Instr_PC       = pc4 - 32'd4;
    Instr_PC_Plus4 = pc4;
    RegisterValue  = rv;
    FWD_REQ_FREEZE = frz;
    #1;
    check({tag, ".flags"}, 32'({Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                                RegWrite, JumpRegister, SignOrZero, Syscall}), 32'(exp_flags));
    check({tag, ".alu"}, 32'(ALUControl), 32'(exp_alu));
    check({tag, ".nia"}, NextInstructionAddress, exp_nia);
  endtask

  initial begin
    RESET = 1'b0;
    Instr = '0; Instr_PC = '0; Instr_PC_Plus4 = '0; RegisterValue = '0;
    FWD_REQ_FREEZE = 1'b0; comment1 = 1'b0;
    RegA = '0; RegB = '0; RegC = '0;
    WriteReg = '0; WriteData = '0; Write = 1'b0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      RegA = 5'(i);
      #1;
      check($sformatf("rst_r%0d", i), DataA, 32'h0);
    end

    // Write R5 with same-cycle read: bypass, then array
    @(negedge CLK);
    RegA = 5'd5; WriteReg = 5'd5; WriteData = 32'hDEADBEEF; Write = 1'b1;
    #1;
    check("bypass_r5", DataA, 32'hDEADBEEF);
    @(posedge CLK);
    #1;
    Write = 1'b0; WriteData = 32'h0;
    #1;
    check("array_r5", DataA, 32'hDEADBEEF);

    // Write R7, then three ports reading the same and different regs
    @(negedge CLK);
    WriteReg = 5'd7; WriteData = 32'h12345678; Write = 1'b1;
    @(posedge CLK);
    #1;
    Write = 1'b0;
    RegA = 5'd7; RegB = 5'd7; RegC = 5'd7;
    #1;
    check("r7_a", DataA, 32'h12345678);
    check("r7_b", DataB, 32'h12345678);
    check("r7_c", DataC, 32'h12345678);
    RegB = 5'd5; RegC = 5'd6;
    #1;
    check("r5_b", DataB, 32'hDEADBEEF);
    check("r6_c", DataC, 32'h0);

    // R0 stays zero
    @(negedge CLK);
    RegA = 5'd0; WriteReg = 5'd0; WriteData = 32'h1; Write = 1'b1;
    #1;
    check("r0_bypass", DataA, 32'h0);
    @(posedge CLK);
    #1;
    Write = 1'b0;
    #1;
    check("r0_array", DataA, 32'h0);

    // Asynchronous reset clears, and overrides a pending write
    @(negedge CLK);
    RESET = 1'b0;
    RegA = 5'd5; RegB = 5'd9; WriteReg = 5'd9; WriteData = 32'hCAFEF00D; Write = 1'b1;
    #1;
    check("rst_r5", DataA, 32'h0);
    check("rst_bypass_r9", DataB, 32'h0);
    @(posedge CLK);
    #1;
    Write = 1'b0;
    RESET = 1'b1;
    #1;
    check("rst_blk_r9", DataB, 32'h0);
    check("rst_r5_after", DataA, 32'h0);

    // Decoder and NIA vectors
    dec_vec("add",     32'h012A4020, 32'h00400008, 32'h0,        1'b0, 11'b01000001000, 6'h20, 32'h00400008);
    dec_vec("jal",     32'h0C000010, 32'h00400004, 32'h0,        1'b0, 11'b10110001000, 6'h21, 32'h00000040);
    dec_vec("beq",     32'h1000FFFF, 32'h00400104, 32'h0,        1'b0, 11'b00010000000, 6'h21, 32'h00400100);
    dec_vec("beq_frz", 32'h1000FFFF, 32'h00400104, 32'h0,        1'b1, 11'b00010000000, 6'h21, 32'h00400104);
    dec_vec("jr",      32'h03E00008, 32'h00400010, 32'h00400020, 1'b0, 11'b00110000100, 6'h08, 32'h00400020);
    dec_vec("jalr",    32'h0120F809, 32'h00400010, 32'h00401234, 1'b0, 11'b11110001100, 6'h09, 32'h00401234);
    dec_vec("syscall", 32'h0000000C, 32'h00400030, 32'h0,        1'b0, 11'b00000000001, 6'h0C, 32'h00400030);
    dec_vec("ll",      32'hC0000000, 32'h00400030, 32'h0,        1'b0, 11'b00001001001, 6'h28, 32'h00400030);
    dec_vec("sc",      32'hE0000000, 32'h00400030, 32'h0,        1'b0, 11'b00000101001, 6'h36, 32'h00400030);
    dec_vec("nop0",    32'h00000000, 32'h00400040, 32'h0,        1'b0, 11'b00000000000, 6'h00, 32'h00400040);
    dec_vec("j_hi",    32'h08000100, 32'hA0000004, 32'h0,        1'b0, 11'b00110000000, 6'h21, 32'hA0000400);
    dec_vec("addi",    32'h2008FFFF, 32'h00400050, 32'h0,        1'b0, 11'b00000011010, 6'h20, 32'h00400050);
    dec_vec("ori",     32'h350800FF, 32'h00400050, 32'h0,        1'b0, 11'b00000011000, 6'h25, 32'h00400050);
    dec_vec("sw",      32'hAD090004, 32'h00400050, 32'h0,        1'b0, 11'b00000110010, 6'h21, 32'h00400050);
    dec_vec("lw",      32'h8D090004, 32'h00400050, 32'h0,        1'b0, 11'b00001011010, 6'h21, 32'h00400050);
    dec_vec("bgezal",  32'h04110002, 32'h00400010, 32'h0,        1'b0, 11'b10010001000, 6'h21, 32'h00400018);
    dec_vec("bne_wrap",32'h14008000, 32'h00010000, 32'h0,        1'b0, 11'b00010000000, 6'h21, 32'hFFFF0000);
    dec_vec("jr_frz",  32'h03E00008, 32'h00400010, 32'h00400020, 1'b1, 11'b00110000100, 6'h08, 32'h00400010);
    dec_vec("unsup",   32'hFC000000, 32'h00400060, 32'h0,        1'b0, 11'b00000000000, 6'h00, 32'h00400060);

    // Decode must not depend on reset
    RESET = 1'b0;
    dec_vec("jal_rst", 32'h0C000010, 32'h00400004, 32'h0,        1'b0, 11'b10110001000, 6'h21, 32'h00000040);
    RESET = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
